// File: rtl/reset_sequencer_ctrl.sv
// Power-up reset sequencer: waits for device init and debounced PLL lock, then releases
// per-domain resets one at a time; lock loss or a software request re-runs the sequence.
//   state     | meaning
//   WAIT_INIT | all domains held, waiting for device init
//   WAIT_LOCK | debouncing PLL lock, lock-timeout watchdog running
//   RELEASE   | releasing domains in index order every STEP_CYCLES
//   RUN       | all domains released
//   HOLD      | all domains re-asserted for STEP_CYCLES before re-locking
module reset_sequencer_ctrl #(
    parameter int N_PLL        = 2,
    parameter int N_DOMAINS    = 4,
    parameter int LOCK_STABLE  = 16,
    parameter int STEP_CYCLES  = 20,
    parameter int LOCK_TIMEOUT = 2000,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 init_done,
    input  logic [N_PLL-1:0]     pll_lock,
    input  logic                 sw_reset_req,
    output logic [N_DOMAINS-1:0] domain_resetn,
    output logic                 seq_done,
    output logic                 lock_fault,
    output logic [2:0]           state
);
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 init_s1_q, init_s2_q;
    logic [N_PLL-1:0]     lock_s1_q, lock_s2_q;
    logic                 sw_s1_q, sw_s2_q, sw_prev_q;
    logic [CNT_W-1:0]     stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0]     timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0]     step_cnt_q, step_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DOMAINS-1:0] dom_q, dom_d;
    logic                 seq_done_q, seq_done_d;
    logic                 lock_fault_q, lock_fault_d;
    logic                 all_lock, sw_edge;

    assign all_lock = &lock_s2_q;
    assign sw_edge  = sw_s2_q & ~sw_prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            init_s1_q     <= 1'b0;
            init_s2_q     <= 1'b0;
            lock_s1_q     <= '0;
            lock_s2_q     <= '0;
            sw_s1_q       <= 1'b0;
            sw_s2_q       <= 1'b0;
            sw_prev_q     <= 1'b0;
            state_q       <= WAIT_INIT;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            step_cnt_q    <= '0;
            idx_q         <= '0;
            dom_q         <= '0;
            seq_done_q    <= 1'b0;
            lock_fault_q  <= 1'b0;
        end else begin
            init_s1_q     <= init_done;
            init_s2_q     <= init_s1_q;
            lock_s1_q     <= pll_lock;
            lock_s2_q     <= lock_s1_q;
            sw_s1_q       <= sw_reset_req;
            sw_s2_q       <= sw_s1_q;
            sw_prev_q     <= sw_s2_q;
            state_q       <= state_d;
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            step_cnt_q    <= step_cnt_d;
            idx_q         <= idx_d;
            dom_q         <= dom_d;
            seq_done_q    <= seq_done_d;
            lock_fault_q  <= lock_fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stable_cnt_d  = stable_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        step_cnt_d    = step_cnt_q;
        idx_d         = idx_q;
        dom_d         = dom_q;
        seq_done_d    = seq_done_q;
        lock_fault_d  = lock_fault_q;
        unique case (state_q)
            WAIT_INIT: begin
                dom_d = '0;
                if (init_s2_q) begin
                    state_d       = WAIT_LOCK;
                    stable_cnt_d  = '0;
                    timeout_cnt_d = '0;
                    step_cnt_d    = '0;
                    idx_d         = '0;
                end
            end
            WAIT_LOCK: begin
                stable_cnt_d = all_lock ? stable_cnt_q + CNT_W'(1) : '0;
                // Timeout only flags the fault; the sequencer keeps waiting for lock.
                if (timeout_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    lock_fault_d  = 1'b1;
                    timeout_cnt_d = '0;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                end
                if (all_lock && stable_cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                    state_d    = RELEASE;
                    idx_d      = '0;
                    step_cnt_d = '0;
                end
            end
            RELEASE: begin
                if (!all_lock || sw_edge) begin
                    state_d    = HOLD;
                    dom_d      = '0;
                    seq_done_d = 1'b0;
                    step_cnt_d = '0;
                end else if (step_cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                    dom_d[idx_q] = 1'b1;
                    idx_d        = idx_q + IDX_W'(1);
                    step_cnt_d   = '0;
                    if (idx_q == IDX_W'(N_DOMAINS - 1)) begin
                        seq_done_d = 1'b1;
                        state_d    = RUN;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!all_lock || sw_edge) begin
                    state_d    = HOLD;
                    dom_d      = '0;
                    seq_done_d = 1'b0;
                    step_cnt_d = '0;
                end
            end
            HOLD: begin
                if (step_cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                    state_d       = WAIT_LOCK;
                    stable_cnt_d  = '0;
                    timeout_cnt_d = '0;
                    step_cnt_d    = '0;
                end else begin
                    step_cnt_d = step_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = WAIT_INIT;
        endcase
    end

    assign domain_resetn = dom_q;
    assign seq_done      = seq_done_q;
    assign lock_fault    = lock_fault_q;
    assign state         = state_q;
endmodule

// File: tb/tb_reset_sequencer_ctrl.sv
// Scoreboard bench for reset_sequencer_ctrl: stimulus queues the expected output transitions
// (with the clock edge they must occur on); the monitor pops one on every observed change.
module tb_reset_sequencer_ctrl;
    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [3:0] dom;
        logic       done;
        logic       fault;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       init_done;
    logic [1:0] pll_lock;
    logic       sw_reset_req;
    logic [3:0] domain_resetn;
    logic       seq_done;
    logic       lock_fault;
    logic [2:0] state;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic stim_done = 1'b0;
    exp_t exp_q[$];

    reset_sequencer_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .init_done     (init_done),
        .pll_lock      (pll_lock),
        .sw_reset_req  (sw_reset_req),
        .domain_resetn (domain_resetn),
        .seq_done      (seq_done),
        .lock_fault    (lock_fault),
        .state         (state)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] st, input logic [3:0] dom,
                        input logic done, input logic fault);
        exp_t e;
        e.cyc   = c;
        e.st    = st;
        e.dom   = dom;
        e.done  = done;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Re-sequence after a HOLD triggered by an input change at cycle r: the first n transitions.
    task automatic push_reseq(input int r, input int n);
        int         offs[7] = '{3, 23, 39, 59, 79, 99, 119};
        logic [2:0] sts[7]  = '{3'd4, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        logic [3:0] doms[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
        for (int i = 0; i < n; i++) push(r + offs[i], sts[i], doms[i], (i == 6), 1'b0);
    endtask

    initial begin
        int r;
        int rs;
        resetn       = 1'b0;
        init_done    = 1'b1;
        pll_lock     = 2'b11;
        sw_reset_req = 1'b0;

        // Power-up: reset state, then full sequence
        push(1, 3'd0, 4'b0000, 1'b0, 1'b0);
        wait_cyc(5);
        resetn = 1'b1;
        r = 5;
        push(r + 3,  3'd1, 4'b0000, 1'b0, 1'b0);
        push(r + 19, 3'd2, 4'b0000, 1'b0, 1'b0);
        push(r + 39, 3'd2, 4'b0001, 1'b0, 1'b0);
        push(r + 59, 3'd2, 4'b0011, 1'b0, 1'b0);
        push(r + 79, 3'd2, 4'b0111, 1'b0, 1'b0);
        push(r + 99, 3'd3, 4'b1111, 1'b1, 1'b0);

        // One-cycle drop of lock[1] in RUN
        r = 110;
        push_reseq(r, 7);
        wait_cyc(r);
        pll_lock = 2'b01;
        wait_cyc(r + 1);
        pll_lock = 2'b11;

        // Lock loss and software request together in RUN: a single HOLD
        r = 240;
        push_reseq(r, 5);
        wait_cyc(r);
        pll_lock     = 2'b01;
        sw_reset_req = 1'b1;
        wait_cyc(r + 1);
        pll_lock     = 2'b11;
        sw_reset_req = 1'b0;

        // Software request held high during RELEASE (0011): exactly one re-sequence
        r = 320;
        push_reseq(r, 7);
        wait_cyc(r);
        sw_reset_req = 1'b1;
        wait_cyc(r + 130);
        sw_reset_req = 1'b0;

        // Toggling lock keeps WAIT_LOCK busy until the timeout flags a sticky fault
        r  = 460;
        rs = r + 2030;
        push(r + 3,    3'd4, 4'b0000, 1'b0, 1'b0);
        push(r + 23,   3'd1, 4'b0000, 1'b0, 1'b0);
        push(r + 2023, 3'd1, 4'b0000, 1'b0, 1'b1);
        push(rs + 18,  3'd2, 4'b0000, 1'b0, 1'b1);
        push(rs + 38,  3'd2, 4'b0001, 1'b0, 1'b1);
        push(rs + 58,  3'd2, 4'b0011, 1'b0, 1'b1);
        for (int c = r; c < rs; c++) begin
            wait_cyc(c);
            pll_lock = ((((c - r) / 10) % 2) == 0) ? 2'b01 : 2'b11;
        end
        wait_cyc(rs);
        pll_lock = 2'b11;

        // Reset mid-RELEASE clears everything on the next edge, including the fault
        wait_cyc(rs + 60);
        resetn = 1'b0;
        push(rs + 61, 3'd0, 4'b0000, 1'b0, 1'b0);
        wait_cyc(rs + 65);
        stim_done = 1'b1;
    end

    initial begin
        logic [8:0] obs;
        logic [8:0] prev_obs;
        exp_t       e;
        prev_obs = '1;
        while (!stim_done) begin
            @(negedge clk);
            obs = {state, domain_resetn, seq_done, lock_fault};
            if (obs !== prev_obs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d got st=%0d dom=%b done=%b fault=%b, required no change",
                             cyc, state, domain_resetn, seq_done, lock_fault);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc == e.cyc && state === e.st && domain_resetn === e.dom &&
                        seq_done === e.done && lock_fault === e.fault) begin
                        n_pass++;
                    end else begin
                        $display("FAIL transition got cyc=%0d st=%0d dom=%b done=%b fault=%b, required cyc=%0d st=%0d dom=%b done=%b fault=%b",
                                 cyc, state, domain_resetn, seq_done, lock_fault,
                                 e.cyc, e.st, e.dom, e.done, e.fault);
                    end
                end
                prev_obs = obs;
            end
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_transitions got %0d still pending, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout at cyc=%0d, required finish", cyc);
        $fatal(1);
    end
endmodule
